// File: rtl/instr_exec.sv
// instr_exec: accumulator instruction executor driven by an upstream PC/ROM.
// Each instruction runs FETCH -> EXEC -> RETIRE, and fetch_ena pulses once in
// RETIRE to advance the upstream PC.
// Optional feature macro: INSTR_EXEC_MUL_EN adds a 5-cycle shift-add MUL
// (opcode 010). Without it, opcode 010 is a 3-cycle no-op that sets the
// sticky illegal flag.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for ena
// FETCH  | latch instr_in into IR
// EXEC   | decode; single-cycle ops write acc/flags on the exit edge
// MUL    | one multiplier bit per cycle, five cycles (MUL build only)
// RETIRE | pulse fetch_ena; continue to FETCH or drop to IDLE
// HALT   | parked until reset
module instr_exec #(
    parameter logic [7:0] ACC_INIT = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ena,
    input  logic [7:0] instr_in,
    output logic       fetch_ena,
    output logic [7:0] acc_out,
    output logic       zero_flag,
    output logic       carry_flag,
    output logic       ovf_flag,
    output logic       busy,
    output logic       halted,
    output logic       illegal
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_LDI  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
`ifdef INSTR_EXEC_MUL_EN
        MUL,
`endif
        RETIRE,
        HALT
    } state_t;

    state_t     state;
    logic [7:0] ir;
    logic [2:0] opcode;
    logic [7:0] operand;
    logic [8:0] sum;
    logic [8:0] diff;
    logic [7:0] alu_acc;
    logic       alu_carry;

    assign opcode  = ir[7:5];
    assign operand = {3'b000, ir[4:0]};
    assign sum     = {1'b0, acc_out} + {1'b0, operand};
    assign diff    = {1'b0, acc_out} - {1'b0, operand};

`ifdef INSTR_EXEC_MUL_EN
    // mul_cnt counts down from 4; the multiplier bit consumed is 4 - mul_cnt,
    // so operand bits are taken LSB first while mcand shifts left.
    logic [2:0]  mul_cnt;
    logic [2:0]  mul_idx;
    logic [12:0] product;
    logic [12:0] mcand;
    logic [12:0] product_next;

    assign mul_idx      = 3'd4 - mul_cnt;
    assign product_next = product + (ir[mul_idx] ? mcand : 13'd0);
`endif

    // Result of the single-cycle ALU ops; diff[8] is the borrow for SUB.
    always_comb begin
        alu_acc   = acc_out;
        alu_carry = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_acc   = sum[7:0];
                alu_carry = sum[8];
            end
            OP_SUB: begin
                alu_acc   = diff[7:0];
                alu_carry = diff[8];
            end
            OP_LDI:  alu_acc = operand;
            OP_AND:  alu_acc = acc_out & operand;
            OP_OR:   alu_acc = acc_out | operand;
            OP_XOR:  alu_acc = acc_out ^ operand;
            default: alu_acc = acc_out;
        endcase
    end

    // Sequencer with registered status outputs and the accumulator datapath.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ir         <= 8'h00;
            acc_out    <= ACC_INIT;
            zero_flag  <= (ACC_INIT == 8'h00);
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
            fetch_ena  <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
`ifdef INSTR_EXEC_MUL_EN
            mul_cnt    <= 3'd0;
            product    <= 13'd0;
            mcand      <= 13'd0;
`endif
        end else begin
            fetch_ena <= 1'b0;
            case (state)
                IDLE: begin
                    if (ena) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    ir    <= instr_in;
                    state <= EXEC;
                end
                EXEC: begin
                    case (opcode)
                        OP_MUL: begin
`ifdef INSTR_EXEC_MUL_EN
                            state   <= MUL;
                            mul_cnt <= 3'd4;
                            product <= 13'd0;
                            mcand   <= {5'b00000, acc_out};
`else
                            state     <= RETIRE;
                            fetch_ena <= 1'b1;
                            illegal   <= 1'b1;
`endif
                        end
                        OP_HALT: begin
                            state  <= HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                        default: begin
                            state      <= RETIRE;
                            fetch_ena  <= 1'b1;
                            acc_out    <= alu_acc;
                            zero_flag  <= (alu_acc == 8'h00);
                            carry_flag <= alu_carry;
                            ovf_flag   <= 1'b0;
                        end
                    endcase
                end
`ifdef INSTR_EXEC_MUL_EN
                MUL: begin
                    product <= product_next;
                    mcand   <= mcand << 1;
                    if (mul_cnt == 3'd0) begin
                        state      <= RETIRE;
                        fetch_ena  <= 1'b1;
                        acc_out    <= product_next[7:0];
                        zero_flag  <= (product_next[7:0] == 8'h00);
                        carry_flag <= 1'b0;
                        ovf_flag   <= |product_next[12:8];
                    end else begin
                        mul_cnt <= mul_cnt - 3'd1;
                    end
                end
`endif
                RETIRE: begin
                    if (ena) begin
                        state <= FETCH;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_exec.md
INSTR_EXEC -- requirements
Module: instr_exec

Interface
REQ-001 SHALL have parameter ACC_INIT, default 8'h00: reset value of the accumulator.
REQ-002 SHALL have input clock, 1 bit: clock, rising edge.
REQ-003 SHALL have input reset, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have input ena, 1 bit: run enable.
REQ-005 SHALL have input instr_in, 8 bits: instruction from the upstream program counter/ROM; [7:5] opcode, [4:0] operand.
REQ-006 SHALL have output fetch_ena, 1 bit: one-cycle pulse that drives the upstream PC ena.
REQ-007 SHALL have output acc_out, 8 bits: accumulator.
REQ-008 SHALL have outputs zero_flag, carry_flag and ovf_flag, 1 bit each: status of the last retired instruction.
REQ-009 SHALL have outputs busy, halted and illegal, 1 bit each: FSM status.

Function
REQ-010 SHALL use a Moore FSM with states IDLE, FETCH, EXEC, MUL, RETIRE and HALT.
REQ-011 IDLE: SHALL go to FETCH when ena=1, else stay in IDLE.
REQ-012 FETCH: SHALL latch instr_in into IR, then go to EXEC.
REQ-013 EXEC: SHALL go to MUL for opcode 010 (when built in), to HALT for opcode 111, else to RETIRE.
REQ-014 RETIRE: SHALL go to FETCH if ena=1, else to IDLE.
REQ-015 HALT: SHALL hold until reset.
REQ-016 fetch_ena SHALL be 1 only in state RETIRE, so the PC advances exactly once per retired instruction and the next instruction is stable in FETCH.
REQ-017 busy SHALL be 1 in FETCH, EXEC, MUL and RETIRE; halted SHALL be 1 only in HALT.
REQ-018 The operand SHALL be zero-extended to 8 bits.
REQ-019 The accumulator and flags SHALL be written on the EXEC exit edge for single-cycle ops and on the last MUL edge for MUL.
REQ-020 Opcode 000 ADD: acc = (acc+op) mod 256; carry = bit 8.
REQ-021 Opcode 001 SUB: acc = (acc-op) mod 256; carry = borrow.
REQ-022 Opcode 010 MUL: SHALL run a shift-add over operand bits 0..4, LSB first, one bit per cycle, for exactly 5 MUL cycles, using a 13-bit product of the acc snapshot; acc = product[7:0]; ovf = |product[12:8]; carry = 0.
REQ-023 Opcodes 011 LDI (acc=op), 100 AND, 101 OR and 110 XOR SHALL clear carry and ovf.
REQ-024 Opcode 111 HALT SHALL leave acc and flags unchanged and SHALL NOT assert fetch_ena.
REQ-025 ADD and SUB SHALL clear ovf.
REQ-026 zero_flag SHALL equal (new acc == 0) on every write.
REQ-027 Latency from FETCH entry to fetch_ena SHALL be 3 cycles for single-cycle ops and 8 cycles for MUL.
REQ-028 ena falling mid-instruction SHALL NOT abort it: the instruction completes, fetch_ena pulses, then the FSM goes to IDLE.
REQ-029 instr_in changes outside FETCH SHALL be ignored.
REQ-030 Instruction 8'h00 (ADD 0) SHALL act as NOP: acc unchanged, zero_flag updated, carry and ovf cleared.

Reset
REQ-031 Reset SHALL force state IDLE, acc=ACC_INIT, IR=0 and the MUL counter and product to 0.
REQ-032 Reset SHALL force fetch_ena, busy, halted, illegal, carry and ovf to 0, and zero_flag to (ACC_INIT==0).
REQ-033 Reset asserted mid-MUL or in HALT SHALL take effect immediately and discard partial results; no fetch_ena pulse SHALL follow.

Configuration
REQ-034 With macro INSTR_EXEC_MUL_EN defined, opcode 010 SHALL execute MUL per REQ-022.
REQ-035 Without INSTR_EXEC_MUL_EN, no MUL state or product register SHALL exist.
REQ-036 Without INSTR_EXEC_MUL_EN, opcode 010 SHALL take 3 cycles, leave acc and flags unchanged, and set sticky illegal=1 until reset.
REQ-037 With INSTR_EXEC_MUL_EN defined, illegal SHALL stay 0.

Verification
REQ-038 Bench SHALL drive ROM sequence ADD 3, SUB 2, MUL 5, NOP from reset -> acc 03, 01, 05, 05; fetch_ena pulses at cycles 3, 6, 14, 17 after ena rises.
REQ-039 Bench SHALL run LDI 3 then MUL 31 -> acc=8'h5D, ovf=0, zero=0, MUL latency 8 cycles.
REQ-040 Bench SHALL run LDI 16 then MUL 16 -> acc=8'h00, ovf=1, zero=1.
REQ-041 Bench SHALL run LDI 1 then SUB 2 -> acc=8'hFF, carry=1; then ADD 1 -> acc=8'h00, carry=1, zero=1.
REQ-042 Bench SHALL drop ena during EXEC of ADD 4 -> acc updated, one fetch_ena pulse, then IDLE with busy=0; reset during MUL cycle 3 -> acc=ACC_INIT, no fetch_ena.
REQ-043 Bench SHALL run HALT -> halted=1, fetch_ena stays 0 for 20 cycles; without INSTR_EXEC_MUL_EN, MUL 5 -> illegal=1 and acc unchanged.
